fir_coef_loader: RTL and testbench

- Upstream stage of the 16-tap FIR. Receives coefficient frames as a byte stream from the UART receiver and assembles them into a shadow bank of 16 x 12-bit coefficients.
- On a complete, valid frame it commits the shadow bank to the active bank in one cycle. The active bank drives FIR coef0..coef15 directly.
- Also generates the FIR enable, and forces a pipeline flush on every coefficient update.

---
 rtl/fir_pkg.sv | 32 +++
 rtl/fir_coef_timeout.sv | 37 +++
 rtl/fir_coef_loader.sv | 204 ++++++++++++++++++++
 tb/tb_fir_coef_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg: shared constants, FSM state encoding and helpers for the 16-tap
// FIR coefficient path.
//   NTAPS     : coefficients per frame
//   CW        : coefficient width in bits
//   BUS_W     : width of a flat coefficient bank (NTAPS*CW)
//   HDR_BYTE  : frame start byte
//   state_t   : loader FSM states (3-bit encoding)
//   coef_slice: extract coefficient k from a flat bank
// ---------------------------------------------------------------------------
package fir_pkg;

    localparam int NTAPS = 16;
    localparam int CW    = 12;
    localparam int BUS_W = NTAPS * CW;

    localparam logic [7:0] HDR_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HI     = 3'd1,
        ST_LO     = 3'd2,
        ST_CHK    = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    function automatic logic [CW-1:0] coef_slice(input logic [BUS_W-1:0] bus,
                                                 input int unsigned       k);
        return bus[k*CW +: CW];
    endfunction

endpackage

// File: rtl/fir_coef_timeout.sv
// ---------------------------------------------------------------------------
// fir_coef_timeout: loadable down-counter used as an inter-byte watchdog.
//   clk      in  1  clock, rising edge
//   rst      in  1  synchronous active-high reset (count cleared)
//   restart  in  1  reload the counter with load_val (has priority)
//   load_val in  W  reload value
//   en       in  1  count down while high; expiry is only reported when high
//   expired  out 1  en && count has reached zero
// With load_val = N-1 and en held high, expired rises N cycles after the
// cycle in which restart was asserted.
// ---------------------------------------------------------------------------
module fir_coef_timeout #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         restart,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (restart) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/fir_coef_loader.sv
// ---------------------------------------------------------------------------
// fir_coef_loader: assembles coefficient frames from a UART byte stream into
// a shadow bank and commits it to the active bank driving the FIR.
// Optional checksum byte enabled by defining FIR_COEF_CHECKSUM_EN.
//   clk_78MHz    in  1          system clock, rising edge
//   rst          in  1          synchronous active-high reset
//   rx_data_i    in  8          received byte
//   rx_valid_i   in  1          one-cycle strobe qualifying rx_data_i
//   fir_en_req_i in  1          global filter enable request
//   coef_flat_o  out NTAPS*CW   active bank, coef k at [k*CW +: CW]
//   coef_valid_o out 1          at least one frame committed
//   en_fir_o     out 1          registered FIR enable (one-cycle flush gap)
//   coef_upd_o   out 1          one-cycle pulse in the COMMIT cycle
//   frame_err_o  out 1          one-cycle pulse on protocol error/timeout
//   busy_o       out 1          frame in progress (state != IDLE)
// Frame: HDR_BYTE, then 16 x {HI byte (upper nibble must be 0), LO byte},
// then the XOR checksum of the 32 payload bytes when the checksum is enabled.
// ---------------------------------------------------------------------------
module fir_coef_loader
    import fir_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 780000
) (
    input  logic             clk_78MHz,
    input  logic             rst,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_valid_i,
    input  logic             fir_en_req_i,
    output logic [BUS_W-1:0] coef_flat_o,
    output logic             coef_valid_o,
    output logic             en_fir_o,
    output logic             coef_upd_o,
    output logic             frame_err_o,
    output logic             busy_o
);

    localparam int IW = $clog2(NTAPS);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);
    localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYC - 1);

    // Input handshake: rx_valid_i is a strobe with no back-pressure; a byte
    // is consumed in exactly the cycle rx_valid_i is high, or dropped if the
    // FSM is not in a receiving state (COMMIT) or, in IDLE, not a header.

    // state is the FSM debug/observation point for checkers.
    state_t           state, state_nxt;
    logic [IW-1:0]    idx;
    logic [3:0]       nib_q;
    logic [BUS_W-1:0] shadow_q;
    logic [BUS_W-1:0] active_q;
    logic             coef_valid_q;
    logic             en_q;
    logic             accept;
    logic             frame_err;
    logic             to_restart;
    logic             to_en;
    logic             to_expired;
`ifdef FIR_COEF_CHECKSUM_EN
    logic [7:0]       chk_q;
`endif

    // Watchdog runs only inside a frame; it reloads on every accepted byte
    // and is held loaded while idle so a new frame starts with a full budget.
    assign to_en      = (state == ST_HI) || (state == ST_LO) || (state == ST_CHK);
    assign to_restart = accept || (state == ST_IDLE);

    fir_coef_timeout #(
        .W(TW)
    ) u_timeout (
        .clk      (clk_78MHz),
        .rst      (rst),
        .restart  (to_restart),
        .load_val (TO_LOAD),
        .en       (to_en),
        .expired  (to_expired)
    );

    // Next-state logic. A byte arriving in the expiry cycle wins over the
    // timeout, since it proves the sender is still alive.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        frame_err = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_valid_i && (rx_data_i == HDR_BYTE)) begin
                    accept    = 1'b1;
                    state_nxt = ST_HI;
                end
            end
            ST_HI: begin
                if (rx_valid_i) begin
                    accept = 1'b1;
                    if (rx_data_i[7:4] != 4'h0) begin
                        frame_err = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_LO;
                    end
                end else if (to_expired) begin
                    frame_err = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_LO: begin
                if (rx_valid_i) begin
                    accept = 1'b1;
                    if (idx == LAST_IDX) begin
`ifdef FIR_COEF_CHECKSUM_EN
                        state_nxt = ST_CHK;
`else
                        state_nxt = ST_COMMIT;
`endif
                    end else begin
                        state_nxt = ST_HI;
                    end
                end else if (to_expired) begin
                    frame_err = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
`ifdef FIR_COEF_CHECKSUM_EN
            ST_CHK: begin
                if (rx_valid_i) begin
                    accept = 1'b1;
                    if (rx_data_i == chk_q) begin
                        state_nxt = ST_COMMIT;
                    end else begin
                        frame_err = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end else if (to_expired) begin
                    frame_err = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
`endif
            ST_COMMIT: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_78MHz) begin
        if (rst) begin
            state        <= ST_IDLE;
            idx          <= '0;
            nib_q        <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            coef_valid_q <= 1'b0;
            en_q         <= 1'b0;
`ifdef FIR_COEF_CHECKSUM_EN
            chk_q        <= '0;
`endif
        end else begin
            state <= state_nxt;

            if ((state == ST_IDLE) && accept) begin
                idx <= '0;
`ifdef FIR_COEF_CHECKSUM_EN
                chk_q <= '0;
`endif
            end

            if ((state == ST_HI) && rx_valid_i) begin
                nib_q <= rx_data_i[3:0];
`ifdef FIR_COEF_CHECKSUM_EN
                chk_q <= chk_q ^ rx_data_i;
`endif
            end

            if ((state == ST_LO) && rx_valid_i) begin
                shadow_q[idx*CW +: CW] <= {nib_q, rx_data_i};
                if (idx != LAST_IDX) begin
                    idx <= idx + 1'b1;
                end
`ifdef FIR_COEF_CHECKSUM_EN
                chk_q <= chk_q ^ rx_data_i;
`endif
            end

            if (state == ST_COMMIT) begin
                active_q     <= shadow_q;
                coef_valid_q <= 1'b1;
            end

            // Low for the cycle after COMMIT so the FIR flushes its delay line.
            en_q <= fir_en_req_i && coef_valid_q && (state != ST_COMMIT);
        end
    end

    assign coef_flat_o  = active_q;
    assign coef_valid_o = coef_valid_q;
    assign en_fir_o     = en_q;
    assign coef_upd_o   = (state == ST_COMMIT);
    assign frame_err_o  = frame_err;
    assign busy_o       = (state != ST_IDLE);

endmodule

// File: tb/tb_fir_coef_loader.sv
// ---------------------------------------------------------------------------
// tb_fir_coef_loader: directed bench for fir_coef_loader with a commit
// scoreboard (expected banks queued when a good frame is sent, popped when
// coef_upd_o fires). Inter-byte timeout shortened to 100 cycles.
// ---------------------------------------------------------------------------
module tb_fir_coef_loader;
    import fir_pkg::*;

    localparam int unsigned TO_CYC = 100;

    logic             clk_78MHz = 1'b0;
    logic             rst;
    logic [7:0]       rx_data_i;
    logic             rx_valid_i;
    logic             fir_en_req_i;
    logic [BUS_W-1:0] coef_flat_o;
    logic             coef_valid_o;
    logic             en_fir_o;
    logic             coef_upd_o;
    logic             frame_err_o;
    logic             busy_o;

    int checks      = 0;
    int failures    = 0;
    int upd_pulses  = 0;
    int err_pulses  = 0;
    int exp_commits = 0;
    int exp_errs    = 0;
    logic last_err;

    logic [BUS_W-1:0] exp_q[$];
    logic [BUS_W-1:0] cur_bank;
    logic [BUS_W-1:0] bank_a, bank_b, bank_x, bank_e;
`ifdef FIR_COEF_CHECKSUM_EN
    logic [BUS_W-1:0] bank_c, bank_d;
`endif

    // clock / reset block
    always #6 clk_78MHz = ~clk_78MHz;

    fir_coef_loader #(
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk_78MHz    (clk_78MHz),
        .rst          (rst),
        .rx_data_i    (rx_data_i),
        .rx_valid_i   (rx_valid_i),
        .fir_en_req_i (fir_en_req_i),
        .coef_flat_o  (coef_flat_o),
        .coef_valid_o (coef_valid_o),
        .en_fir_o     (en_fir_o),
        .coef_upd_o   (coef_upd_o),
        .frame_err_o  (frame_err_o),
        .busy_o       (busy_o)
    );

    always @(negedge clk_78MHz) begin
        if (!rst) begin
            if (coef_upd_o)  upd_pulses++;
            if (frame_err_o) err_pulses++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [BUS_W-1:0] obs,
                         input logic [BUS_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic drive_byte(input logic [7:0] b);
        @(posedge clk_78MHz); #1;
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        @(negedge clk_78MHz);
        last_err = frame_err_o;
        @(posedge clk_78MHz); #1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
    endtask

    task automatic send_frame(input logic [BUS_W-1:0] bank, input int ntaps,
                              input bit bad_chk);
        logic [7:0] hi, lo, chk;
        chk = 8'h00;
        drive_byte(HDR_BYTE);
        for (int k = 0; k < ntaps; k++) begin
            hi = {4'h0, bank[k*CW+8 +: 4]};
            lo = bank[k*CW +: 8];
            drive_byte(hi);
            drive_byte(lo);
            chk = chk ^ hi ^ lo;
        end
`ifdef FIR_COEF_CHECKSUM_EN
        if (ntaps == NTAPS) drive_byte(bad_chk ? (chk ^ 8'h01) : chk);
`else
        if (bad_chk) chk = 8'h00;
`endif
    endtask

    task automatic rand_bank(output logic [BUS_W-1:0] bank);
        for (int k = 0; k < NTAPS; k++) bank[k*CW +: CW] = CW'($urandom_range(0, 4095));
    endtask

    // Waits for coef_upd_o, then checks the bank against the scoreboard and
    // the en_fir_o sequence {commit cycle, flush cycle, cycle after}.
    task automatic wait_commit(input string tag, input logic [2:0] exp_en);
        bit found = 0;
        logic [BUS_W-1:0] exp_bank;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_78MHz);
            if (coef_upd_o) begin
                found = 1;
                break;
            end
        end
        check({tag, "_upd_seen"}, BUS_W'(found), BUS_W'(1));
        exp_bank = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (found) begin
            check({tag, "_en_commit"}, BUS_W'(en_fir_o), BUS_W'(exp_en[2]));
            @(negedge clk_78MHz);
            check({tag, "_upd_one_cycle"}, BUS_W'(coef_upd_o), BUS_W'(0));
            check({tag, "_bank"}, coef_flat_o, exp_bank);
            check({tag, "_valid"}, BUS_W'(coef_valid_o), BUS_W'(1));
            check({tag, "_en_flush"}, BUS_W'(en_fir_o), BUS_W'(exp_en[1]));
            @(negedge clk_78MHz);
            check({tag, "_en_after"}, BUS_W'(en_fir_o), BUS_W'(exp_en[0]));
            cur_bank = exp_bank;
        end
    endtask

    initial begin
        int n_to;
        rst          = 1'b1;
        rx_data_i    = 8'h00;
        rx_valid_i   = 1'b0;
        fir_en_req_i = 1'b0;
        cur_bank     = '0;
        repeat (3) @(posedge clk_78MHz);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk_78MHz);
        check("rst_coef", coef_flat_o, '0);
        check("rst_valid", BUS_W'(coef_valid_o), '0);
        check("rst_en", BUS_W'(en_fir_o), '0);
        check("rst_upd", BUS_W'(coef_upd_o), '0);
        check("rst_err", BUS_W'(frame_err_o), '0);
        check("rst_busy", BUS_W'(busy_o), '0);

        // Non-header byte in IDLE is ignored
        drive_byte(8'h33);
        check("idle_junk_err", BUS_W'(last_err), '0);
        @(negedge clk_78MHz);
        check("idle_junk_busy", BUS_W'(busy_o), '0);

        // Frame A: coef k = 0x100+k, loaded with the filter disabled
        for (int k = 0; k < NTAPS; k++) bank_a[k*CW +: CW] = CW'(12'h100 + k);
        exp_q.push_back(bank_a);
        exp_commits++;
        send_frame(bank_a, NTAPS, 0);
        wait_commit("frame_a", 3'b000);
        check("frame_a_tap0", BUS_W'(coef_slice(coef_flat_o, 0)), BUS_W'(12'h100));
        check("frame_a_tap15", BUS_W'(coef_slice(coef_flat_o, 15)), BUS_W'(12'h10F));

        // Enable request takes effect two edges later
        @(posedge clk_78MHz); #1 fir_en_req_i = 1'b1;
        repeat (2) @(negedge clk_78MHz);
        check("en_on", BUS_W'(en_fir_o), BUS_W'(1));

        // Frame B: random, with a mid-frame header value as data and 0xFFF
        rand_bank(bank_b);
        bank_b[3*CW +: CW] = 12'h0A5;
        bank_b[9*CW +: CW] = 12'hFFF;
        exp_q.push_back(bank_b);
        exp_commits++;
        send_frame(bank_b, NTAPS, 0);
        wait_commit("frame_b", 3'b101);

        // Bad HI byte at tap 5
        rand_bank(bank_x);
        send_frame(bank_x, 5, 0);
        drive_byte(8'h1F);
        exp_errs++;
        check("hi_err_pulse", BUS_W'(last_err), BUS_W'(1));
        @(negedge clk_78MHz);
        check("hi_err_busy", BUS_W'(busy_o), '0);
        check("hi_err_err_gone", BUS_W'(frame_err_o), '0);
        check("hi_err_bank", coef_flat_o, cur_bank);

        // Timeout after 20 payload bytes
        rand_bank(bank_x);
        send_frame(bank_x, 10, 0);
        n_to = 0;
        for (int n = 1; n <= 150; n++) begin
            @(negedge clk_78MHz);
            if (frame_err_o) begin
                n_to = n;
                break;
            end
        end
        exp_errs++;
        check("timeout_cycle", BUS_W'(n_to), BUS_W'(TO_CYC));
        @(negedge clk_78MHz);
        check("timeout_busy", BUS_W'(busy_o), '0);
        check("timeout_bank", coef_flat_o, cur_bank);

`ifdef FIR_COEF_CHECKSUM_EN
        // Good checksum commits, corrupted checksum errors without commit
        rand_bank(bank_c);
        exp_q.push_back(bank_c);
        exp_commits++;
        send_frame(bank_c, NTAPS, 0);
        wait_commit("chk_good", 3'b101);
        rand_bank(bank_d);
        send_frame(bank_d, NTAPS, 1);
        exp_errs++;
        check("chk_bad_err", BUS_W'(last_err), BUS_W'(1));
        @(negedge clk_78MHz);
        check("chk_bad_upd", BUS_W'(coef_upd_o), '0);
        check("chk_bad_bank", coef_flat_o, cur_bank);
`endif

        // Reset at tap 8 clears everything; next frame commits normally
        rand_bank(bank_x);
        send_frame(bank_x, 8, 0);
        @(posedge clk_78MHz); #1 rst = 1'b1;
        repeat (2) @(posedge clk_78MHz);
        #1 rst = 1'b0;
        @(negedge clk_78MHz);
        check("midrst_coef", coef_flat_o, '0);
        check("midrst_valid", BUS_W'(coef_valid_o), '0);
        check("midrst_en", BUS_W'(en_fir_o), '0);
        check("midrst_upd", BUS_W'(coef_upd_o), '0);
        check("midrst_err", BUS_W'(frame_err_o), '0);
        check("midrst_busy", BUS_W'(busy_o), '0);
        cur_bank = '0;
        rand_bank(bank_e);
        exp_q.push_back(bank_e);
        exp_commits++;
        send_frame(bank_e, NTAPS, 0);
        wait_commit("after_rst", 3'b001);

        // Final report
        repeat (3) @(posedge clk_78MHz);
        check("sb_empty", BUS_W'(exp_q.size()), '0);
        check("upd_count", BUS_W'(upd_pulses), BUS_W'(exp_commits));
        check("err_count", BUS_W'(err_pulses), BUS_W'(exp_errs));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
